izh_spike_encoder: RTL

Downstream stage of the Izhikevich neuron core. Consumes the 8-bit signed membrane-voltage sample stream and detects spikes using threshold plus re-arm hysteresis. Measures the inter-spike interval (ISI) in enabled cycles and queues ISI events in a small FIFO behind a valid/ready handshake. Also provides a one-cycle spike strobe, a wrapping spike counter and a sticky overflow flag.

---
 rtl/izh_pkg.sv | 13 +
 rtl/izh_event_fifo.sv | 47 ++++
 rtl/izh_spike_encoder.sv | 71 +++++++
 3 files changed

// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron core and its downstream stages.
// Threshold defaults are reused by the neuron core's test benches.
package izh_pkg;

   typedef enum logic {
      ARMED   = 1'b0,
      REFRACT = 1'b1
   } izh_state_t;

   localparam logic signed [7:0] IZH_SPIKE_TH = 8'sd19;
   localparam logic signed [7:0] IZH_REARM_TH = 8'sd0;

endpackage

// File: rtl/izh_event_fifo.sv
// First-word-fall-through event FIFO; pointers carry an extra wrap bit to tell
// full from empty. A pop on an empty FIFO is ignored, a push while full is accepted only alongside a pop.
module izh_event_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // The head reads as zero while empty so the output never shows stale data.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/izh_spike_encoder.sv
// Spike detector with threshold/re-arm hysteresis, saturating ISI measurement
// and a queued ISI event stream behind a valid/ready handshake.
module izh_spike_encoder
   import izh_pkg::*;
#(
   parameter int               ISI_W    = 12,
   parameter int               DEPTH    = 4,
   parameter logic signed [7:0] SPIKE_TH = IZH_SPIKE_TH,
   parameter logic signed [7:0] REARM_TH = IZH_REARM_TH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [7:0]       v_in,
   output logic             spike,
   output logic [15:0]      spike_cnt,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [ISI_W-1:0] evt_isi,
   output logic             overflow
);

   izh_state_t       state;
   logic [ISI_W-1:0] isi_q;
   logic [ISI_W-1:0] isi_next;
   logic             spike_hit;
   logic             fifo_full;
   logic             fifo_empty;

   assign spike_hit = ena && (state == ARMED) && ($signed(v_in) > SPIKE_TH);
   assign isi_next  = (&isi_q) ? isi_q : isi_q + 1'b1;
   assign evt_valid = !fifo_empty;

   izh_event_fifo #(
      .WIDTH (ISI_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (spike_hit),
      .push_data (isi_next),
      .pop       (evt_ready),
      .rd_data   (evt_isi),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A full FIFO only drops the event when the consumer is not popping this cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ARMED;
         isi_q     <= '0;
         spike     <= 1'b0;
         spike_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         spike <= spike_hit;
         if (spike_hit) spike_cnt <= spike_cnt + 16'd1;
         if (spike_hit && fifo_full && !evt_ready) overflow <= 1'b1;
         if (ena) begin
            isi_q <= spike_hit ? '0 : isi_next;
            if (state == ARMED) begin
               if ($signed(v_in) > SPIKE_TH) state <= REFRACT;
            end else begin
               if ($signed(v_in) < REARM_TH) state <= ARMED;
            end
         end
      end
   end

endmodule
